ram8_bist: RTL and testbench

- Built-in self-test initiator for the 8-word, 16-bit `ram8` register file.
- Drives `ram8`'s load, address and data_in ports. Reads back through ram8's combinational data_out.
- Runs a four-phase write/verify sweep and reports pass/fail with the first failing location.
- Sits between the top-level test/debug controls and a `ram8` instance. The block is the initiator side of the ram8 write/read interface.

---
 rtl/ram8_bist.sv | 126 ++++++++++++
 tb/tb_ram8_bist.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/ram8_bist.sv
// Built-in self-test initiator for the ram8 register file: writes a seeded
// pattern, verifies it, writes its complement, verifies again, reports result.
module ram8_bist #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] pattern,
  output logic              mem_load,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              fail_phase,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_data
);

  typedef enum logic [2:0] {IDLE, WR0, RD0, WR1, RD1, DONE} state_t;

  localparam logic [ADDR_W-1:0] A_MAX = '1;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] seed;
  logic [DATA_W-1:0] expected_word;
  logic [DATA_W-1:0] read_word;
  logic              at_max;
  logic              mismatch;

  // The second sweep uses the complement so every bit is exercised both ways.
  assign expected_word = seed ^ DATA_W'(a);
  assign read_word     = (state == RD1) ? ~expected_word : expected_word;
  assign at_max        = (a == A_MAX);
  assign mismatch      = (mem_data_out != read_word);
  assign mem_address   = a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = WR0;
      WR0:  if (at_max) state_next = RD0;
      RD0: begin
        if (mismatch)    state_next = DONE;
        else if (at_max) state_next = WR1;
      end
      WR1:  if (at_max) state_next = RD1;
      RD1:  if (mismatch || at_max) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_load    = 1'b0;
    mem_data_in = '0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      WR0: begin
        mem_load    = 1'b1;
        mem_data_in = expected_word;
        busy        = 1'b1;
      end
      RD0: busy = 1'b1;
      WR1: begin
        mem_load    = 1'b1;
        mem_data_in = ~expected_word;
        busy        = 1'b1;
      end
      RD1: busy = 1'b1;
      DONE: done = 1'b1;
      default: ;
    endcase
  end

  // Address counter, latched seed and the sticky result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a          <= '0;
      seed       <= '0;
      pass       <= 1'b0;
      fail_phase <= 1'b0;
      fail_addr  <= '0;
      fail_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            seed       <= pattern;
            a          <= '0;
            pass       <= 1'b0;
            fail_phase <= 1'b0;
            fail_addr  <= '0;
            fail_data  <= '0;
          end
        end
        WR0, WR1: a <= a + 1'b1;
        RD0, RD1: begin
          if (mismatch) begin
            fail_phase <= (state == RD1);
            fail_addr  <= a;
            fail_data  <= mem_data_out;
            pass       <= 1'b0;
            a          <= '0;
          end else begin
            a <= a + 1'b1;
            if (state == RD1 && at_max) pass <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ram8_bist.sv
// Table-driven bench for ram8_bist with a behavioural ram8 that can hold one
// bit of one word stuck at 0.
module tb_ram8_bist;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] pattern = '0;
  logic        mem_load;
  logic [2:0]  mem_address;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic        busy, done, pass, fail_phase;
  logic [2:0]  fail_addr;
  logic [15:0] fail_data;

  logic [2:0]  stuck_addr = '0;
  logic [15:0] stuck_mask = 16'hFFFF;
  logic [15:0] mem [8];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram8_bist #(.ADDR_W(3), .DATA_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern),
    .mem_load(mem_load), .mem_address(mem_address), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out), .busy(busy), .done(done), .pass(pass),
    .fail_phase(fail_phase), .fail_addr(fail_addr), .fail_data(fail_data)
  );

  always @(posedge clk) if (mem_load) mem[mem_address] <= mem_data_in;
  assign mem_data_out = mem[mem_address] & ((mem_address == stuck_addr) ? stuck_mask : 16'hFFFF);

  typedef struct {
    string       name;
    logic [15:0] pattern;
    logic [2:0]  stuck_addr;
    logic [15:0] stuck_mask;
    int          glitch_cycle;
    int          exp_done;
    int          exp_busy;
    logic        exp_pass;
    logic        exp_phase;
    logic [2:0]  exp_addr;
    logic [15:0] exp_data;
    logic        chk_wr1;
    logic [15:0] exp_w0a0;
    logic [15:0] exp_w0a5;
    logic [15:0] exp_w1a3;
  } vec_t;

  vec_t vecs [5];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    int cyc, busy_cnt, done_cyc, dz_err, nwr;
    logic [15:0] w0 [8];
    logic [15:0] w1 [8];
    for (int i = 0; i < 8; i++) begin w0[i] = 'x; w1[i] = 'x; end
    stuck_addr = v.stuck_addr;
    stuck_mask = v.stuck_mask;
    @(posedge clk); #1;
    start = 1'b1;
    pattern = v.pattern;
    @(posedge clk); #1;
    start = 1'b0;
    pattern = 16'h0F0F;
    checkOutput({v.name, " cleared_at_start"}, {13'd0, pass, fail_phase, fail_addr, fail_data}, 32'd0);
    cyc = 1; busy_cnt = 0; done_cyc = 0; dz_err = 0; nwr = 0;
    while (cyc <= 100) begin
      if (busy) busy_cnt++;
      if (!mem_load && mem_data_in != 16'h0) dz_err++;
      if (mem_load) begin
        if (nwr < 8) w0[mem_address] = mem_data_in;
        else         w1[mem_address] = mem_data_in;
        nwr++;
      end
      if (done) begin done_cyc = cyc; break; end
      if (cyc == v.glitch_cycle) begin start = 1'b1; pattern = 16'hFFFF; end
      else start = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    checkOutput({v.name, " done_cycle"}, done_cyc, v.exp_done);
    checkOutput({v.name, " busy_cycles"}, busy_cnt, v.exp_busy);
    checkOutput({v.name, " pass"}, pass, v.exp_pass);
    checkOutput({v.name, " fail_phase"}, fail_phase, v.exp_phase);
    checkOutput({v.name, " fail_addr"}, fail_addr, v.exp_addr);
    checkOutput({v.name, " fail_data"}, fail_data, v.exp_data);
    checkOutput({v.name, " data_in_zero_when_idle"}, dz_err, 0);
    checkOutput({v.name, " wr0_addr0"}, w0[0], v.exp_w0a0);
    checkOutput({v.name, " wr0_addr5"}, w0[5], v.exp_w0a5);
    if (v.chk_wr1) checkOutput({v.name, " wr1_addr3"}, w1[3], v.exp_w1a3);
    @(posedge clk); #1;
    checkOutput({v.name, " done_one_cycle"}, {done, busy}, 2'b00);
    @(posedge clk); #1;
    checkOutput({v.name, " result_held"}, {busy, pass, fail_addr}, {1'b0, v.exp_pass, v.exp_addr});
  endtask

  initial begin
    int bad, done_seen;
    vecs[0] = '{"clean_1234", 16'h1234, 3'd0, 16'hFFFF, 0, 33, 32, 1'b1, 1'b0, 3'd0, 16'h0000,
                1'b1, 16'h1234, 16'h1231, 16'hEDC8};
    vecs[1] = '{"stuck_a5_b0", 16'h1234, 3'd5, 16'hFFFE, 0, 15, 14, 1'b0, 1'b0, 3'd5, 16'h1230,
                1'b0, 16'h1234, 16'h1231, 16'h0000};
    vecs[2] = '{"stuck_a3_b15", 16'h1234, 3'd3, 16'h7FFF, 0, 29, 28, 1'b0, 1'b1, 3'd3, 16'h6DC8,
                1'b1, 16'h1234, 16'h1231, 16'hEDC8};
    vecs[3] = '{"start_while_busy", 16'h1234, 3'd0, 16'hFFFF, 10, 33, 32, 1'b1, 1'b0, 3'd0, 16'h0000,
                1'b1, 16'h1234, 16'h1231, 16'hEDC8};
    vecs[4] = '{"clean_a5a5", 16'hA5A5, 3'd0, 16'hFFFF, 0, 33, 32, 1'b1, 1'b0, 3'd0, 16'h0000,
                1'b1, 16'hA5A5, 16'hA5A0, 16'h5A59};

    // Reset held with start asserted: nothing may move.
    start = 1'b1;
    pattern = 16'h1234;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if ({mem_load, busy, done, pass, fail_phase, fail_addr, fail_data, mem_address, mem_data_in} != '0) bad++;
    end
    checkOutput("reset_outputs_zero", bad, 0);
    start = 1'b0;
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (busy || mem_load || done) bad++;
    end
    checkOutput("idle_after_reset", bad, 0);

    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    // Reset in the middle of WR1 aborts the run without a done pulse.
    stuck_mask = 16'hFFFF;
    @(posedge clk); #1;
    start = 1'b1;
    pattern = 16'h1234;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i < 20; i++) begin @(posedge clk); #1; end
    checkOutput("midrun_in_wr1", {mem_load, busy}, 2'b11);
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_reset_immediate", {mem_load, busy, done, mem_data_in}, '0);
    done_seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (done || mem_load) done_seen++;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) done_seen++;
    end
    checkOutput("midrun_no_done", done_seen, 0);
    applyStimulus(vecs[0]);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
